// File: rtl/xsleena_irq_pkg.sv
// Shared types and source indices for the Xain'd Sleena interrupt controller.
// Pure declarations; no logic, no latency, no backpressure.
package xsleena_irq_pkg;

    typedef enum logic {
        IRQ_IDLE,
        IRQ_PENDING
    } irq_state_t;

    localparam int SRC_NMI  = 0;
    localparam int SRC_FIRQ = 1;
    localparam int SRC_IRQ  = 2;
    localparam int SRC_SUB  = 3;
    localparam int N_SRC    = 4;

endpackage

// File: rtl/xsleena_irq_ctrl_if.sv
// Decoded strobes, video timing and interrupt lines between the decoder/video side and the controller.
// Wires only; no latency, no backpressure.
interface xsleena_irq_ctrl_if #(
    parameter int VCNT_W    = 9,
    parameter int DBG_CNT_W = 8
);
    logic [VCNT_W-1:0]      VCNT;
    logic                   VBLK;
    logic                   W3A09n;
    logic                   W3A0An;
    logic                   W3A0Bn;
    logic                   W3A0Cn;
    logic                   SUB_IRQSETn;
    logic                   SUB_IRQCLRn;
    logic                   NMIn;
    logic                   FIRQn;
    logic                   IRQn;
    logic                   SUB_IRQn;
    logic [4*DBG_CNT_W-1:0] DBG_OVR;

    modport master (
        output VCNT, VBLK, W3A09n, W3A0An, W3A0Bn, W3A0Cn, SUB_IRQSETn, SUB_IRQCLRn,
        input  NMIn, FIRQn, IRQn, SUB_IRQn, DBG_OVR
    );

    modport slave (
        input  VCNT, VBLK, W3A09n, W3A0An, W3A0Bn, W3A0Cn, SUB_IRQSETn, SUB_IRQCLRn,
        output NMIn, FIRQn, IRQn, SUB_IRQn, DBG_OVR
    );

endinterface

// File: rtl/xsleena_irq_latch.sv
// One interrupt source: IDLE/PENDING latch with set-wins priority, optional overrun counter (XSLEENA_IRQ_DEBUG_EN).
// Latency: pend_n and ovr update one clk after set/clr. No backpressure; set while pending is an overrun.
import xsleena_irq_pkg::*;

module xsleena_irq_latch #(
    parameter int DBG_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 set,
    input  logic                 clr,
    output logic                 pend_n,
    output logic [DBG_CNT_W-1:0] ovr
);

    irq_state_t state;

    always_ff @(posedge clk) begin
        if (RST) begin
            state  <= IRQ_IDLE;
            pend_n <= 1'b1;
        end else begin
            unique case (state)
                IRQ_IDLE: begin
                    if (set) begin
                        state  <= IRQ_PENDING;
                        pend_n <= 1'b0;
                    end
                end
                IRQ_PENDING: begin
                    // A fresh event arriving with the clear must not be lost.
                    if (clr && !set) begin
                        state  <= IRQ_IDLE;
                        pend_n <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef XSLEENA_IRQ_DEBUG_EN
    always_ff @(posedge clk) begin
        if (RST) begin
            ovr <= '0;
        end else if (state == IRQ_PENDING && set && !clr && ovr != '1) begin
            ovr <= ovr + DBG_CNT_W'(1);
        end
    end
`else
    assign ovr = '0;
`endif

endmodule

// File: rtl/xsleena_irq_ctrl.sv
// Main/sub CPU interrupt generator: rising-edge detect on strobes and video timing feeding four held latches.
// Latency: line changes 2 clk after the raw input edge. No backpressure; lines hold until cleared.
// Optional overrun counters on DBG_OVR when XSLEENA_IRQ_DEBUG_EN is defined, else DBG_OVR is 0.
import xsleena_irq_pkg::*;

module xsleena_irq_ctrl #(
    parameter int FIRQ_BIT  = 3,
    parameter int VCNT_W    = 9,
    parameter int DBG_CNT_W = 8
) (
    input  logic              clk,
    input  logic              RST,
    xsleena_irq_ctrl_if.slave bus
);

    if (FIRQ_BIT >= VCNT_W) begin : g_bad_firq_bit
        $error("FIRQ_BIT must index into VCNT");
    end

    logic [N_SRC-1:0]     set_raw, clr_raw;
    logic [2*N_SRC-1:0]   raw, prev, ev;
    logic [N_SRC-1:0]     pend_n;
    logic [DBG_CNT_W-1:0] ovr [N_SRC];

    assign set_raw[SRC_NMI]  = bus.VBLK;
    assign set_raw[SRC_FIRQ] = bus.VCNT[FIRQ_BIT];
    assign set_raw[SRC_IRQ]  = bus.SUB_IRQSETn;
    assign set_raw[SRC_SUB]  = bus.W3A0Cn;

    assign clr_raw[SRC_NMI]  = bus.W3A09n;
    assign clr_raw[SRC_FIRQ] = bus.W3A0An;
    assign clr_raw[SRC_IRQ]  = bus.W3A0Bn;
    assign clr_raw[SRC_SUB]  = bus.SUB_IRQCLRn;

    assign raw = {clr_raw, set_raw};

    // History tracks the inputs even in reset so the first cycle after release sees no false edge.
    always_ff @(posedge clk) begin
        prev <= raw;
        if (RST) begin
            ev <= '0;
        end else begin
            ev <= raw & ~prev;
        end
    end

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        xsleena_irq_latch #(
            .DBG_CNT_W(DBG_CNT_W)
        ) u_latch (
            .clk   (clk),
            .RST   (RST),
            .set   (ev[i]),
            .clr   (ev[N_SRC+i]),
            .pend_n(pend_n[i]),
            .ovr   (ovr[i])
        );
        assign bus.DBG_OVR[i*DBG_CNT_W +: DBG_CNT_W] = ovr[i];
    end

    assign bus.NMIn     = pend_n[SRC_NMI];
    assign bus.FIRQn    = pend_n[SRC_FIRQ];
    assign bus.IRQn     = pend_n[SRC_IRQ];
    assign bus.SUB_IRQn = pend_n[SRC_SUB];

endmodule

// File: tb/tb_xsleena_irq_ctrl.sv
// Randomized + directed bench for xsleena_irq_ctrl with a queue-based scoreboard and a rule-level reference model.
module tb_xsleena_irq_ctrl;

    typedef struct packed {
        logic [3:0]  lines_n;   // {SUB_IRQn, IRQn, FIRQn, NMIn}
        logic [31:0] dbg;
    } exp_t;

    logic clk = 1'b0;
    logic RST;
    always #5 clk = ~clk;

    xsleena_irq_ctrl_if #(.VCNT_W(9), .DBG_CNT_W(8)) bus ();

    xsleena_irq_ctrl #(.FIRQ_BIT(3), .VCNT_W(9), .DBG_CNT_W(8)) dut (
        .clk(clk),
        .RST(RST),
        .bus(bus)
    );

    // Stimulus state
    logic       cur_rst, cur_vblk, cur_w9, cur_wa, cur_wb, cur_wc, cur_sset, cur_sclr;
    logic [8:0] cur_vcnt;

    // Reference model: input levels one and two cycles back, pending flags, overrun counts
    logic [7:0] h1, h2;
    logic       m_rst1;
    bit         pend [4];
    int         cnt  [4];

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   count_firq = 0;
    int   firq_falls = 0;
    logic prev_firq  = 1'b1;

    function automatic logic [7:0] cur_vec();
        // clear sources in the upper nibble, set sources in the lower, both in NMI/FIRQ/IRQ/SUB order
        return {cur_sclr, cur_wb, cur_wa, cur_w9, cur_wc, cur_sset, cur_vcnt[3], cur_vblk};
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        RST             = cur_rst;
        bus.VBLK        = cur_vblk;
        bus.VCNT        = cur_vcnt;
        bus.W3A09n      = cur_w9;
        bus.W3A0An      = cur_wa;
        bus.W3A0Bn      = cur_wb;
        bus.W3A0Cn      = cur_wc;
        bus.SUB_IRQSETn = cur_sset;
        bus.SUB_IRQCLRn = cur_sclr;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            bit s, c;
            s = !m_rst1 && h1[i]   && !h2[i];
            c = !m_rst1 && h1[i+4] && !h2[i+4];
            if (cur_rst) begin
                pend[i] = 0;
                cnt[i]  = 0;
            end else begin
                if (pend[i] && s && !c && cnt[i] != 255) cnt[i]++;
                if (s)      pend[i] = 1;
                else if (c) pend[i] = 0;
            end
            e.lines_n[i] = !pend[i];
`ifdef XSLEENA_IRQ_DEBUG_EN
            e.dbg[i*8 +: 8] = cnt[i][7:0];
`endif
        end
        q.push_back(e);
        h2     = h1;
        h1     = cur_vec();
        m_rst1 = cur_rst;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Monitor: the DUT presents a fresh line state every cycle
    initial begin
        exp_t e;
        logic [3:0] act;
        forever begin
            @(negedge clk);
            cyc++;
            act = {bus.SUB_IRQn, bus.IRQn, bus.FIRQn, bus.NMIn};
            if (count_firq && prev_firq === 1'b1 && bus.FIRQn === 1'b0) firq_falls++;
            prev_firq = bus.FIRQn;
            if (q.size() >= 2) begin
                e = q.pop_front();
                tests++;
                if (act !== e.lines_n) begin
                    fails++;
                    $display("FAIL lines cyc=%0d actual=%b expected=%b", cyc, act, e.lines_n);
                end
                tests++;
                if (bus.DBG_OVR !== e.dbg) begin
                    fails++;
                    $display("FAIL dbg_ovr cyc=%0d actual=%h expected=%h", cyc, bus.DBG_OVR, e.dbg);
                end
            end
        end
    end

    initial begin
        // Reset held with VBLK and VCNT[3] already high: no NMI/FIRQ may follow release.
        cur_rst = 1; cur_vblk = 1; cur_vcnt = 9'd8;
        cur_w9 = 1; cur_wa = 1; cur_wb = 1; cur_wc = 1; cur_sset = 1; cur_sclr = 1;
        RST = 1; bus.VBLK = 1; bus.VCNT = 9'd8;
        bus.W3A09n = 1; bus.W3A0An = 1; bus.W3A0Bn = 1; bus.W3A0Cn = 1;
        bus.SUB_IRQSETn = 1; bus.SUB_IRQCLRn = 1;
        h1 = cur_vec(); h2 = cur_vec(); m_rst1 = 1;
        for (int i = 0; i < 4; i++) begin pend[i] = 0; cnt[i] = 0; end
        ticks(10);
        cur_rst = 0;
        ticks(10);

        // NMI from VBLK rise, cleared by a 3-cycle W3A09n pulse
        cur_vblk = 0; ticks(2);
        cur_vblk = 1; ticks(3);
        cur_w9 = 0;   ticks(3);
        cur_w9 = 1;   ticks(3);

        // One frame of lines: FIRQ on every VCNT[3] rise, cleared a few lines later
        count_firq = 1;
        for (int v = 0; v <= 261; v++) begin
            cur_vcnt = 9'(v);
            cur_wa   = ((v % 16) == 12) ? 1'b0 : 1'b1;
            tick();
        end
        cur_wa = 1;
        ticks(4);
        count_firq = 0;
        tests++;
        if (firq_falls != 16) begin
            fails++;
            $display("FAIL firq_per_frame actual=%0d expected=16", firq_falls);
        end

        // Set and clear land in the same cycle while FIRQ is pending: set wins
        cur_vcnt = 9'd0; tick();
        cur_vcnt = 9'd8; ticks(3);
        cur_vcnt = 9'd0; tick();
        cur_vcnt = 9'd7; cur_wa = 0; tick();
        cur_vcnt = 9'd8; cur_wa = 1; ticks(4);
        cur_wa = 0; tick();
        cur_wa = 1; ticks(3);

        // Sub IRQ set/clear, then main IRQ from the sub side cleared by W3A0Bn
        cur_wc = 0;   ticks(2); cur_wc = 1;   ticks(3);
        cur_sclr = 0; ticks(2); cur_sclr = 1; ticks(3);
        cur_sset = 0; ticks(2); cur_sset = 1; ticks(3);
        cur_wb = 0;   ticks(2); cur_wb = 1;   ticks(3);

        // Repeated VBLK rises without clearing, enough to saturate an 8-bit overrun count
        for (int n = 0; n < 303; n++) begin
            cur_vblk = 0; tick();
            cur_vblk = 1; tick();
        end
        ticks(2);
        cur_rst = 1; tick();
        cur_rst = 0; ticks(3);

        // Random traffic with occasional resets
        for (int n = 0; n < 2000; n++) begin
            cur_rst  = ($urandom_range(0, 199) == 0);
            cur_w9   = ($urandom_range(0, 3) != 0);
            cur_wa   = ($urandom_range(0, 3) != 0);
            cur_wb   = ($urandom_range(0, 3) != 0);
            cur_wc   = ($urandom_range(0, 3) != 0);
            cur_sset = ($urandom_range(0, 3) != 0);
            cur_sclr = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) cur_vblk = ~cur_vblk;
            cur_vcnt = (cur_vcnt >= 9'd261) ? 9'd0 : cur_vcnt + 9'd1;
            tick();
        end
        cur_rst = 0;
        ticks(3);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
